// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator: mode codes, LED width,
// per-mode sequence lengths and the pattern lookup used by the top level.
package led_pattern_pkg;

  localparam int LED_W = 16;

  localparam logic [2:0] MODE_IDLE     = 3'd0;
  localparam logic [2:0] MODE_FILL     = 3'd1;
  localparam logic [2:0] MODE_DRAIN    = 3'd2;
  localparam logic [2:0] MODE_WALK     = 3'd3;
  localparam logic [2:0] MODE_BLINK    = 3'd4;
  localparam logic [2:0] MODE_CONVERGE = 3'd5;

  localparam int SEQ_LEN_LONG  = 16;
  localparam int SEQ_LEN_SHORT = 8;

  // Last step index of a mode's sequence (L-1).
  function automatic logic [3:0] seq_last(input logic [2:0] m);
    if (m == MODE_BLINK || m == MODE_CONVERGE) begin
      return 4'(SEQ_LEN_SHORT - 1);
    end
    return 4'(SEQ_LEN_LONG - 1);
  endfunction

  // Unused codes 6 and 7 fall back to idle.
  function automatic logic [2:0] map_mode(input logic [2:0] m);
    return (m > MODE_CONVERGE) ? MODE_IDLE : m;
  endfunction

  // LED image for step k of mode m, built bit by bit.
  function automatic logic [LED_W-1:0] pattern(input logic [2:0] m, input logic [3:0] k);
    logic [LED_W-1:0] p;
    int ki;
    p  = '0;
    ki = int'(k);
    for (int i = 0; i < LED_W; i++) begin
      case (m)
        MODE_FILL:     p[i] = (i <= ki);
        MODE_DRAIN:    p[i] = (i <= (LED_W - 1 - ki));
        MODE_WALK:     p[i] = (i == ki);
        MODE_BLINK:    p[i] = ~k[0];
        MODE_CONVERGE: p[i] = (i <= ki) || (i >= (LED_W - 1 - ki));
        default:       p[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 and flags the cycle on which the
// pattern should advance. A synchronous clear restarts the count.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] c_reg;

  // Terminal count reached while counting; clear suppresses the tick.
  assign tick = en && !clear && (c_reg == CW'(TICK_DIV - 1));

  // Prescaler count: clear wins, then wrap on tick, else increment when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg <= '0;
    end else if (clear) begin
      c_reg <= '0;
    end else if (en) begin
      c_reg <= tick ? '0 : c_reg + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: plays the selected mode's pattern sequence, one
// step every TICK_DIV cycles, and pulses flick at each sequence wrap.
// Optional feature: define LED_PATTERN_PAUSE_EN to add a pause input.
module led_pattern_gen #(
  parameter int TICK_DIV = 4,
  parameter int LED_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
`ifdef LED_PATTERN_PAUSE_EN
  input  logic             pause,
`endif
  output logic [LED_W-1:0] led,
  output logic             flick,
  output logic [2:0]       prev_mode
);
  import led_pattern_pkg::*;

  logic [2:0]       prev_mode_reg, prev_mode_next;
  logic [3:0]       k_reg, k_next;
  logic [LED_W-1:0] led_reg, led_next;
  logic             flick_reg, flick_next;
  logic             mode_change;
  logic             idle;
  logic             run;
  logic             step_tick;

  assign mode_change = (mode != prev_mode_reg);
  assign idle        = (prev_mode_reg == MODE_IDLE);

`ifdef LED_PATTERN_PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(mode_change || idle),
    .en   (run),
    .tick (step_tick)
  );

  // Next state: mode change has priority, idle parks at step 0, else advance on tick.
  always_comb begin
    prev_mode_next = prev_mode_reg;
    k_next         = k_reg;
    flick_next     = 1'b0;
    if (mode_change) begin
      prev_mode_next = map_mode(mode);
      k_next         = '0;
    end else if (idle) begin
      k_next = '0;
    end else if (step_tick) begin
      if (k_reg == seq_last(prev_mode_reg)) begin
        k_next     = '0;
        flick_next = 1'b1;
      end else begin
        k_next = k_reg + 4'd1;
      end
    end
    // Pattern from next-state so led lines up with prev_mode and k.
    led_next = LED_W'(pattern(prev_mode_next, k_next));
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_mode_reg <= MODE_IDLE;
      k_reg         <= '0;
      led_reg       <= '0;
      flick_reg     <= 1'b0;
    end else begin
      prev_mode_reg <= prev_mode_next;
      k_reg         <= k_next;
      led_reg       <= led_next;
      flick_reg     <= flick_next;
    end
  end

  assign led       = led_reg;
  assign flick     = flick_reg;
  assign prev_mode = prev_mode_reg;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen: directed scenarios plus random mode
// changes, checked every cycle against a position-based reference model.
module tb_led_pattern_gen;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic [15:0] led;
  logic        flick;
  logic [2:0]  prev_mode;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: mode being played and cycles elapsed since it started.
  int m_prev = 0;
  int m_pos  = 0;

  led_pattern_gen #(.TICK_DIV(TD), .LED_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .led      (led),
    .flick    (flick),
    .prev_mode(prev_mode)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int seq_len(input int m);
    return (m >= 4) ? 8 : 16;
  endfunction

  function automatic logic [15:0] model_led();
    int k;
    logic [31:0] v;
    if (m_prev == 0) return 16'h0000;
    k = (m_pos / TD) % seq_len(m_prev);
    case (m_prev)
      1: v = (32'd1 << (k + 1)) - 32'd1;
      2: v = 32'h0000FFFF >> k;
      3: v = 32'd1 << k;
      4: v = (k % 2 == 0) ? 32'h0000FFFF : 32'h0;
      default: v = ((32'd1 << (k + 1)) - 32'd1) | (32'h0000FFFF << (15 - k));
    endcase
    return v[15:0];
  endfunction

  function automatic logic model_flick();
    return (m_prev != 0) && (m_pos > 0) && (m_pos % (TD * seq_len(m_prev)) == 0);
  endfunction

  // One clock: update the model at the edge, compare all outputs mid-cycle.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_prev = 0;
      m_pos  = 0;
    end else if (int'(mode) != m_prev) begin
      m_prev = (mode > 3'd5) ? 0 : int'(mode);
      m_pos  = 0;
    end else if (m_prev != 0) begin
      m_pos++;
    end
    @(negedge clk);
    check_val("led", 32'(led), 32'(model_led()));
    check_val("flick", 32'(flick), 32'(model_flick()));
    check_val("prev_mode", 32'(prev_mode), 32'(m_prev));
  endtask

  initial begin
    int n;
    rst  = 1'b1;
    mode = 3'd0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    check_val("reset_led", 32'(led), 32'h0);
    check_val("reset_prev", 32'(prev_mode), 32'h0);

    // Idle for 200 cycles.
    repeat (200) step();
    check_val("idle_led", 32'(led), 32'h0);

    // Fill mode timing.
    mode = 3'd1;
    step();
    check_val("fill_k0", 32'(led), 32'h0001);
    repeat (4) step();
    check_val("fill_k1", 32'(led), 32'h0003);
    repeat (60) step();
    check_val("fill_wrap_flick", 32'(flick), 32'h1);
    check_val("fill_wrap_led", 32'(led), 32'h0001);

    // Walk mode: each position held TD cycles, then wrap.
    mode = 3'd3;
    step();
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = 32'd1 << (i / TD);
      check_val("walk", 32'(led), w);
      step();
    end
    check_val("walk_wrap_flick", 32'(flick), 32'h1);
    check_val("walk_wrap_led", 32'(led), 32'h0001);

    // Mode change coincident with a tick at k=5.
    repeat (23) step();
    check_val("walk_k5", 32'(led), 32'h0020);
    mode = 3'd4;
    step();
    check_val("chg_led", 32'(led), 32'hFFFF);
    check_val("chg_prev", 32'(prev_mode), 32'h4);
    check_val("chg_flick", 32'(flick), 32'h0);

    // Converge wrap at k=7, then unused code 6.
    mode = 3'd5;
    step();
    repeat (31) step();
    check_val("conv_k7", 32'(led), 32'hFFFF);
    step();
    check_val("conv_flick", 32'(flick), 32'h1);
    check_val("conv_wrap_led", 32'(led), 32'h8001);
    mode = 3'd6;
    step();
    check_val("mode6_prev", 32'(prev_mode), 32'h0);
    check_val("mode6_led", 32'(led), 32'h0);
    step();

    // Asynchronous reset between clock edges.
    mode = 3'd3;
    repeat (10) step();
    #2 rst = 1'b1;
    #1;
    check_val("arst_led", 32'(led), 32'h0);
    check_val("arst_flick", 32'(flick), 32'h0);
    check_val("arst_prev", 32'(prev_mode), 32'h0);
    step();
    rst = 1'b0;

    // Random mode sequences, including codes 6/7 and quick changes.
    for (int t = 0; t < 40; t++) begin
      mode = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 150);
      repeat (n) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
